// File: rtl/tff_bank_sched.sv
// tff_bank_sched: a WIDTH-bit toggle flip-flop bank shared by two round-robin
// requesters. Each accepted request walks the bank to its target word, flipping
// at most MAX_TOG bits per clock, and signals completion with a one-cycle done.
//
// Handshake: a requester's word is taken when its valid and ready are both high
// at a rising clock edge. Ready is only ever offered in IDLE, and only to the
// arbitration winner. Valid may be raised or dropped at any time; the word is
// sampled at the accepting edge only, and later changes are ignored.
module tff_bank_sched #(
    parameter int WIDTH   = 8,
    parameter int MAX_TOG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_d,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             owner_b,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] target;
    logic             last_b;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] t_step;
    logic             acc_a;
    logic             acc_b;
    logic             accept;
    logic [WIDTH-1:0] win_d;
    logic             last_step;

    assign pend      = target ^ q;
    assign acc_a     = a_valid & a_ready;
    assign acc_b     = b_valid & b_ready;
    assign accept    = acc_a | acc_b;
    assign win_d     = acc_b ? b_d : a_d;
    assign last_step = ((pend ^ t_step) == '0);

    // Pick the lowest-indexed set bits of the pending difference, up to MAX_TOG.
    always_comb begin
        int cnt;
        t_step = '0;
        cnt    = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pend[i] && (cnt < MAX_TOG)) begin
                t_step[i] = 1'b1;
                cnt       = cnt + 1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: leave IDLE only for real work, return once the last bits flip.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && ((win_d ^ q) != '0)) state_next = UPDATE;
            UPDATE:  if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: round-robin grant in IDLE (A by default when nobody asks), toggles in UPDATE.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        t       = '0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                a_ready = ~b_valid | (a_valid & last_b);
                b_ready = b_valid & (~a_valid | ~last_b);
            end
            UPDATE: begin
                t    = t_step;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Bank, captured request, ownership and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            target  <= '0;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            done    <= 1'b0;
        end else begin
            q    <= q ^ t;
            done <= 1'b0;
            if (state == IDLE && accept) begin
                target  <= win_d;
                owner_b <= acc_b;
                last_b  <= acc_b;
                done    <= ((win_d ^ q) == '0);
            end else if (state == UPDATE && last_step) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tff_bank_sched.sv
// Directed bench for tff_bank_sched with hand-computed expectations.
module tb_tff_bank_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] a_d = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] b_d = '0;
    logic [7:0] q;
    logic [7:0] t;
    logic       busy;
    logic       owner_b;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int done_seen = 0;

    logic [7:0] exp_q[$];
    logic       exp_owner[$];

    tff_bank_sched #(.WIDTH(8), .MAX_TOG(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_d(a_d),
        .b_valid(b_valid), .b_ready(b_ready), .b_d(b_d),
        .q(q), .t(t), .busy(busy), .owner_b(owner_b), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step one clock; land 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Step at least once, then until done is seen or the budget runs out.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        step();
        while (!done && n < 30) begin
            step();
            n++;
        end
        check({tag, "_done_timeout"}, done, 1'b1);
    endtask

    // Switching-current cap and idle-quiet toggle vector, every cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("t_popcount", ($countones(t) <= 2), 1'b1);
            check("t_idle_zero", (!busy && (t != 8'h00)), 1'b0);
            if (done) done_seen++;
        end
    end

    initial begin
        // Test 1: single A transfer 00 -> A5
        do_reset();
        mon_en = 1'b1;
        check("rst_q", q, 8'h00);
        check("rst_t", t, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_owner", owner_b, 1'b0);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_b_ready", b_ready, 1'b0);
        a_valid = 1'b1; a_d = 8'hA5;
        #1;
        check("t1_a_ready", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        #1;
        check("t1_t0", t, 8'h05);
        check("t1_busy0", busy, 1'b1);
        check("t1_a_ready_upd", a_ready, 1'b0);
        step();
        check("t1_q1", q, 8'h05);
        check("t1_t1", t, 8'hA0);
        check("t1_busy1", busy, 1'b1);
        step();
        check("t1_q_final", q, 8'hA5);
        check("t1_done", done, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_owner", owner_b, 1'b0);
        step();
        check("t1_done_pulse", done, 1'b0);

        // Test 3: zero-work request after reaching 3C
        a_valid = 1'b1; a_d = 8'h3C;
        step();
        a_valid = 1'b0;
        wait_done("t3_pre");
        check("t3_pre_q", q, 8'h3C);
        a_valid = 1'b1; a_d = 8'h3C;
        step();
        a_valid = 1'b0;
        #1;
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_t", t, 8'h00);
        check("t3_q", q, 8'h3C);
        step();
        check("t3_done_pulse", done, 1'b0);

        // Test 2: both requesters held, grants alternate starting with A
        do_reset();
        exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_owner = '{1'b0, 1'b1, 1'b0, 1'b1};
        a_valid = 1'b1; a_d = 8'h11;
        b_valid = 1'b1; b_d = 8'h22;
        #1;
        check("t2_first_a_ready", a_ready, 1'b1);
        check("t2_first_b_ready", b_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_done("t2");
            check("t2_q", q, exp_q.pop_front());
            check("t2_owner", owner_b, exp_owner.pop_front());
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        check("t2_no_extra_done", done, 1'b0);

        // Test 4: B transfer 00 -> FF, four steps of two bits
        do_reset();
        b_valid = 1'b1; b_d = 8'hFF;
        #1;
        check("t4_b_ready", b_ready, 1'b1);
        check("t4_a_ready", a_ready, 1'b0);
        step();
        b_valid = 1'b0;
        check("t4_t0", t, 8'h03);
        step();
        check("t4_t1", t, 8'h0C);
        step();
        check("t4_t2", t, 8'h30);
        step();
        check("t4_t3", t, 8'hC0);
        check("t4_busy", busy, 1'b1);
        step();
        check("t4_q", q, 8'hFF);
        check("t4_done", done, 1'b1);
        check("t4_owner", owner_b, 1'b1);

        // Test 5: reset during the second UPDATE cycle aborts the transfer
        do_reset();
        done_seen = 0;
        a_valid = 1'b1; a_d = 8'hFF;
        step();
        a_valid = 1'b0;
        step();
        check("t5_q_mid", q, 8'h03);
        check("t5_busy_mid", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_q", q, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        for (int k = 0; k < 6; k++) step();
        check("t5_done_never", done_seen, 0);

        // Test 6: A data change during UPDATE ignored; B waits for IDLE
        a_valid = 1'b1; a_d = 8'h0F;
        b_valid = 1'b1; b_d = 8'h55;
        #1;
        check("t6_a_wins", a_ready, 1'b1);
        check("t6_b_loses", b_ready, 1'b0);
        step();
        a_valid = 1'b0; a_d = 8'hF0;
        #1;
        check("t6_b_ready_u0", b_ready, 1'b0);
        check("t6_t0", t, 8'h03);
        step();
        check("t6_b_ready_u1", b_ready, 1'b0);
        check("t6_q1", q, 8'h03);
        step();
        check("t6_q", q, 8'h0F);
        check("t6_done", done, 1'b1);
        check("t6_owner", owner_b, 1'b0);
        check("t6_b_ready_idle", b_ready, 1'b1);
        b_valid = 1'b0;
        step();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
